// File: rtl/p66bpkg.sv
// Shared definitions for the 66b block scheduler: sync headers, block types,
// the fixed control blocks it can emit, and the scheduler state encoding.
package p66bpkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam logic [7:0] BT_IDLE = 8'h1E;
  localparam logic [7:0] BT_OS   = 8'h4B;

  localparam logic [6:0] E_CODE  = 7'h1E;

  // Idle control block: all eight control codes are /I/ (zero)
  localparam logic [65:0] IDLE_BLK = {56'h0, BT_IDLE, SH_CTRL};

  // Error control block: all eight control codes are /E/
  localparam logic [65:0] ERR_BLK  = {{8{E_CODE}}, BT_IDLE, SH_CTRL};

  // Ordered sets: {rest, O0, D3, D2, D1, type, header}
  localparam logic [65:0] LF_OS    = {28'h0, 4'h0, 8'h01, 8'h00, 8'h00, BT_OS, SH_CTRL};
  localparam logic [65:0] RF_OS    = {28'h0, 4'h0, 8'h02, 8'h00, 8'h00, BT_OS, SH_CTRL};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

endpackage

// File: rtl/p66btxsched.sv
// Block scheduler in front of the 66b->64b TX gearbox. Every gearbox slot
// receives exactly one legal block: encoder data, idle, an error block on a
// mid-packet underrun, or a Local/Remote Fault ordered set. Packets are never
// preempted and a minimum number of idle blocks follows each packet.
module p66btxsched
  import p66bpkg::*;
#(
  parameter int LGIDLE   = 4,
  parameter int MIN_IDLE = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_local_fault,
  input  logic        i_remote_fault,
  input  logic        S_VALID,
  output logic        S_READY,
  input  logic [65:0] S_DATA,
  input  logic        S_LAST,
  input  logic        M_READY,
  output logic [65:0] M_DATA,
  output logic        o_underrun,
  output logic        o_fault_tx
);

  localparam logic [LGIDLE-1:0] GAP_INIT = LGIDLE'(MIN_IDLE);

  state_t              state;
  logic [LGIDLE-1:0]   gap;
  logic [65:0]         blk_p1;
  logic                under_p1;
  logic                fault_p1;

  logic                fault_req;
  logic [65:0]         fault_os;

  // Gap counter never wraps below zero
  function automatic logic [LGIDLE-1:0] gap_dec(input logic [LGIDLE-1:0] g);
    return (g == '0) ? '0 : g - LGIDLE'(1);
  endfunction

  // Local Fault outranks Remote Fault whenever both are requested
  assign fault_req = i_local_fault | i_remote_fault;
  assign fault_os  = i_local_fault ? LF_OS : RF_OS;

  // Encoder may only advance in a gearbox slot, and never while a gap or
  // a pending fault owns the slot
  assign S_READY = M_READY &&
                   ((state == ST_DATA) || (state == ST_DRAIN) ||
                    ((state == ST_IDLE) && (gap == '0) && !fault_req));

  assign M_DATA     = blk_p1;
  assign o_underrun = under_p1;
  assign o_fault_tx = fault_p1;

  // ---- slot stage: scheduler FSM, gap counter and output block register ----
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= ST_IDLE;
      gap      <= '0;
      blk_p1   <= IDLE_BLK;
      under_p1 <= 1'b0;
      fault_p1 <= 1'b0;
    end else begin
      under_p1 <= 1'b0;
      if (M_READY) begin
        case (state)
          ST_IDLE: begin
            if (fault_req) begin
              blk_p1   <= fault_os;
              state    <= ST_FAULT;
              fault_p1 <= 1'b1;
            end else if (gap != '0) begin
              blk_p1 <= IDLE_BLK;
              gap    <= gap_dec(gap);
            end else if (S_VALID) begin
              blk_p1 <= S_DATA;
              if (S_LAST) gap   <= GAP_INIT;
              else        state <= ST_DATA;
            end else begin
              blk_p1 <= IDLE_BLK;
            end
          end
          ST_DATA: begin
            if (S_VALID) begin
              blk_p1 <= S_DATA;
              if (S_LAST) begin
                state <= ST_IDLE;
                gap   <= GAP_INIT;
              end
            end else begin
              blk_p1   <= ERR_BLK;
              under_p1 <= 1'b1;
              state    <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            // Rest of the broken packet is swallowed up to its last block
            blk_p1 <= IDLE_BLK;
            if (S_VALID && S_LAST) begin
              state <= ST_IDLE;
              gap   <= GAP_INIT;
            end
          end
          ST_FAULT: begin
            if (fault_req) begin
              blk_p1 <= fault_os;
            end else begin
              blk_p1   <= IDLE_BLK;
              state    <= ST_IDLE;
              gap      <= GAP_INIT;
              fault_p1 <= 1'b0;
            end
          end
          default: begin
            blk_p1   <= IDLE_BLK;
            state    <= ST_IDLE;
            fault_p1 <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
